mandelbrot_reader: RTL

MANDELBROT_READER -- requirements
Module: mandelbrot_reader

---
 rtl/mandelbrot_pkg.sv | 24 ++
 rtl/mandelbrot_reader_fifo.sv | 69 ++++++
 rtl/mandelbrot_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
//------------------------------------------------------------------------------
// Module : mandelbrot_pkg
// Brief  : Shared definitions for the Mandelbrot pixel reader: reader FSM
//          state encoding and the pixel / byte widths of the stream.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mandelbrot_pkg;

  localparam int PIXEL_W = 4;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_STORE     = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mandelbrot_reader_fifo.sv
//------------------------------------------------------------------------------
// Module : mandelbrot_reader_fifo
// Brief  : DEPTH x WIDTH synchronous FIFO. Outputs come straight from flops
//          (storage, read pointer, occupancy), so out_valid rises the cycle
//          after a push into an empty FIFO.
// Ports  : clk, reset      - clock, synchronous active-high reset
//          push, push_data - write side (ignored when full)
//          pop             - read side (ignored when empty)
//          out_data        - head entry
//          out_valid       - FIFO not empty
//          full            - occupancy == DEPTH
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mandelbrot_reader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];

  // Guards make overflow and underflow impossible regardless of the caller.
  assign w_push = push && !full;
  assign w_pop  = pop && out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;   // wraps modulo DEPTH (power of two)
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mandelbrot_reader.sv
//------------------------------------------------------------------------------
// Module : mandelbrot_reader
// Brief  : Drives the Mandelbrot engine one pixel at a time, collects the
//          4-bit iteration counts and streams them out as bytes through a
//          small FIFO, flagging the byte that holds the frame's final pixel.
// Config : MANDELBROT_READER_PACK_EN - when defined, two pixels are packed
//          per byte {second, first}; otherwise each pixel is sent as
//          {4'h0, pixel}.
// Ports  : clk, reset             - clock, synchronous active-high reset
//          start, continuous      - frame start / auto-restart control
//          run                    - one-cycle pixel request to the engine
//          running, finished      - engine busy / end-of-frame flags
//          ctr_in                 - engine pixel value
//          out_data/valid/last/ready - byte stream
//          frame_done             - pulse after the last byte is accepted
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mandelbrot_reader
  import mandelbrot_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PIXELS = 76800
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               continuous,
  output logic               run,
  input  logic               running,
  input  logic               finished,
  input  logic [PIXEL_W-1:0] ctr_in,
  output logic [BYTE_W-1:0]  out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               frame_done
);

  localparam int                CNT_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(PIXELS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_pix;
  logic                r_frame_done;
  logic                w_run;
  logic                w_push;
  logic [BYTE_W-1:0]   w_push_byte;
  logic                w_full;
  logic [BYTE_W:0]     w_fifo_out;

`ifdef MANDELBROT_READER_PACK_EN
  logic [PIXEL_W-1:0]  r_held;
  logic                r_half;     // a first-of-pair nibble is waiting in r_held
`endif

  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    w_push       = 1'b0;
    w_push_byte  = {{(BYTE_W-PIXEL_W){1'b0}}, ctr_in};
    case (r_state)
      ST_IDLE:      if (start) w_state_next = ST_ISSUE;
      ST_ISSUE: begin
        // Only request a pixel when its byte is guaranteed a FIFO slot.
        if (!w_full) begin
          w_run        = 1'b1;
          w_state_next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: if (running)  w_state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!running) w_state_next = ST_STORE;
      ST_STORE: begin
`ifdef MANDELBROT_READER_PACK_EN
        // Second of a pair completes the byte; a lone final pixel is flushed.
        w_push = r_half || finished;
        if (r_half) w_push_byte = {ctr_in, r_held};
`else
        w_push = 1'b1;
`endif
        w_state_next = (!finished || continuous) ? ST_ISSUE : ST_IDLE;
      end
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pix        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= out_valid && out_ready && out_last;
      // Frame end always follows the engine's finished flag; a frame is
      // error-free when finished lands on LAST_PIX. Any mismatch realigns
      // the counter to 0 for the next frame.
      if (r_state == ST_STORE)
        r_pix <= (finished || (r_pix == LAST_PIX)) ? '0 : r_pix + 1'b1;
    end
  end

`ifdef MANDELBROT_READER_PACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held <= '0;
      r_half <= 1'b0;
    end else if (r_state == ST_STORE) begin
      if (r_half || finished) begin
        r_half <= 1'b0;
      end else begin
        r_held <= ctr_in;
        r_half <= 1'b1;
      end
    end
  end
`endif

  mandelbrot_reader_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data ({finished, w_push_byte}),
    .pop       (out_ready),
    .out_data  (w_fifo_out),
    .out_valid (out_valid),
    .full      (w_full)
  );

  assign run        = w_run;
  assign out_last   = w_fifo_out[BYTE_W];
  assign out_data   = w_fifo_out[BYTE_W-1:0];
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire
